// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined Hack-style ALU (zx,nx,zy,ny,f,no).
// Define ALU_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef ALU_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s1_f;
    logic             s1_no;

    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] x_pre;
    logic [WIDTH-1:0] y_pre;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] res;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        x_pre = ctrl[5] ? '0 : x;
        x_pre = ctrl[4] ? ~x_pre : x_pre;
        y_pre = ctrl[3] ? '0 : y;
        y_pre = ctrl[2] ? ~y_pre : y_pre;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_f     <= 1'b0;
            s1_no    <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1_x     <= x_pre;
            s1_y     <= y_pre;
            s1_f     <= ctrl[1];
            s1_no    <= ctrl[0];
        end
    end

    // Carry out of the add is dropped: arithmetic is modulo 2^WIDTH.
    always_comb begin
        sum = s1_x + s1_y;
        r   = s1_f ? sum : (s1_x & s1_y);
        res = s1_no ? ~r : r;
    end

    // Flags are registered rather than derived from out so they read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            zr        <= 1'b0;
            ng        <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            out       <= res;
            zr        <= (res == '0);
            ng        <= res[WIDTH-1];
        end
    end

`ifdef ALU_PIPE_OVF_EN
    // Overflow looks at the pre-negation sum, so no has no effect on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (s2_en) begin
            ovf <= s1_f && (s1_x[WIDTH-1] == s1_y[WIDTH-1])
                        && (sum[WIDTH-1] != s1_x[WIDTH-1]);
        end
    end
`endif

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal values 4..64.
REQ-002 clk  input  1  rising-edge clock; all state clocked here.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 x  input  WIDTH  first operand, two's complement.
REQ-007 y  input  WIDTH  second operand, two's complement.
REQ-008 ctrl  input  6  {zx,nx,zy,ny,f,no}, bit 5 = zx.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 zr  output  1  result equals zero.
REQ-013 ng  output  1  result negative.
REQ-014 ovf  output  1  signed add overflow; present only under ALU_PIPE_OVF_EN.

Function
REQ-015 Transfer occurs on a clock edge where valid and ready are both high; beats are never dropped, duplicated or reordered.
REQ-016 Stage 1 registers x' = zx ? 0 : x, then x' = nx ? ~x' : x'; same for y' with zy/ny; also registers f, no and s1_valid.
REQ-017 Stage 2 registers r = f ? x'+y' : x'&y', then out = no ? ~r : r; zr = (out == 0); ng = out[WIDTH-1]; registers s2_valid (= out_valid).
REQ-018 Addition is modulo 2^WIDTH; carry out is discarded.
REQ-019 Advance enables: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en (combinational).
REQ-020 On s1_en, stage 1 loads in_valid and the operands; on s2_en, stage 2 loads s1_valid and the stage-1 result.
REQ-021 Latency is exactly 2 clk edges from input transfer to out_valid with no backpressure; throughput is one beat per cycle.
REQ-022 While out_valid=1 and out_ready=0, out/zr/ng/ovf and out_valid stay stable.
REQ-023 With both stages full and out_ready=0, in_ready=0; raising out_ready re-asserts in_ready in the same cycle.
REQ-024 Simultaneous output and input transfers in one cycle keep full throughput with no bubble.
REQ-025 A stage whose valid bit is 0 may hold any data; its contents have no visible effect.

Reset
REQ-026 rst asserted immediately clears s1_valid and s2_valid, so out_valid=0; it does not wait for clk.
REQ-027 While rst is high, out, zr, ng and ovf read 0 and in_ready reads 1.
REQ-028 Beats in flight when rst asserts are discarded; the first beat after deassertion sees 2-cycle latency.
REQ-029 Stage-1 data registers reset to 0.

Configuration
REQ-030 With ALU_PIPE_OVF_EN defined, port ovf exists and is registered in stage 2 with out.
REQ-031 ovf = 1 when f=1 and x'[MSB]==y'[MSB]!=sum[MSB]; ovf = 0 when f=0.
REQ-032 ovf ignores no.
REQ-033 Without ALU_PIPE_OVF_EN, port ovf and its logic are absent; all other behaviour is identical.

Verification
REQ-034 WIDTH=16, x=5, y=3, ctrl=000010, out_ready=1 -> two edges later out=8, zr=0, ng=0, out_valid pulses once.
REQ-035 Any x/y, ctrl=111111 -> out=1; ctrl=101010 -> out=0, zr=1; ctrl=111010 -> out=16'hFFFF, ng=1.
REQ-036 x=16'h7FFF, y=1, ctrl=000010 -> out=16'h8000, ng=1, ovf=1 if ALU_PIPE_OVF_EN is defined; ctrl=000000 with the same operands -> ovf=0.
REQ-037 Backpressure: out_ready=0 for 4 cycles while 3 beats are offered back-to-back -> 2 beats accepted, then in_ready=0 and out holds. Release -> 3 results in order, none lost or duplicated.
REQ-038 Back-to-back stream of 100 random beats with out_ready=1 -> one result per cycle, each matching a software model at WIDTH=16 and WIDTH=8.
REQ-039 rst pulsed mid-clock with both stages full -> out_valid falls before the next edge and in_ready=1. After release, a new beat emerges 2 edges later with no stale result.
